rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
- Parametrised successor to the RTC transfer controller.
- Generates the multiplexed address/data bus cycles (ad_n, cs_n, rd_n, wr_n, bus direction) for the external RTC.
- Adds configurable phase timing, a generic data width, burst transfers with address auto-increment, and a read-data capture path.
- Sits between the register-access FSM (user side) and the FPGA pads for the RTC bus.

Parameters:
- DATA_W, 8, width of the address/data bus and of the user addr/wdata/rdata.
- SETUP_CYC, 2, cycles from cs_n low to the strobe falling edge (min 1).
- PULSE_CYC, 4, cycles the rd_n/wr_n strobe is held low (min 1).
- HOLD_CYC, 2, cycles from strobe rising edge to cs_n rising edge (min 1).
- GAP_CYC, 4, cycles cs_n stays high after each phase (min 1).
- BURST_W, 4, width of burst_len.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request strobe; sampled only in IDLE.
- rnw  in  1  1 = read, 0 = write; latched on start.
- addr  in  DATA_W  first register address; latched on start.
- burst_len  in  BURST_W  beats minus one (0 = single beat); latched on start.
- wdata  in  DATA_W  write data; sampled on the cycle wdata_ack is high.
- wdata_ack  out  1  one-cycle pulse: wdata consumed for the current beat.
- rdata  out  DATA_W  captured read data.
- rdata_valid  out  1  one-cycle pulse when rdata updates.
- busy  out  1  high from the start-accept edge until the return to IDLE.
- done  out  1  one-cycle pulse on the return to IDLE.
- ad_n  out  1  0 = address phase, 1 = data phase.
- cs_n, rd_n, wr_n  out  1  active-low RTC strobes.
- bus_out  out  DATA_W  value driven on the pads.
- bus_oe  out  1  1 = FPGA drives the bus.
- bus_in  in  DATA_W  pad input.

Behaviour:
- Reset (asynchronous) outputs:
  - cs_n = rd_n = wr_n = ad_n = 1.
  - bus_oe = 0; bus_out = 0; rdata = 0.
  - busy = done = rdata_valid = wdata_ack = 0.
  - State = IDLE; counters cleared.
- Reset mid-transfer aborts immediately; no completion pulse is produced.
- States:
  - IDLE -> A_SETUP -> A_PULSE -> A_HOLD -> A_GAP -> D_SETUP -> D_PULSE -> D_HOLD -> D_GAP.
  - After D_GAP: go to A_SETUP for the next beat, or to IDLE when the last beat is done.
  - One down-counter is reloaded with the next phase length on each transition.
- IDLE: when start = 1, latch rnw, addr, burst_len; beat counter = 0; go to A_SETUP; busy = 1.
- Address phase:
  - cs_n = 0, ad_n = 0, bus_oe = 1, bus_out = current address.
  - wr_n low during A_PULSE only.
- A_GAP: cs_n = 1, bus_oe = 0, ad_n = 1.
- Data phase, write:
  - wdata_ack pulses in the first D_SETUP cycle; wdata is registered onto bus_out that cycle.
  - bus_oe = 1 for D_SETUP..D_HOLD; wr_n low during D_PULSE.
- Data phase, read:
  - bus_oe = 0 throughout; rd_n low during D_PULSE.
  - bus_in is captured into rdata on the last D_PULSE cycle; rdata_valid pulses the following cycle.
- Strobe exclusivity: rd_n and wr_n are never low simultaneously. bus_oe is never 1 while rd_n = 0.
- Timing per beat: cs_n-low time is SETUP+PULSE+HOLD per phase; beat length = 2*(SETUP+PULSE+HOLD+GAP) cycles (24 at defaults).
- Burst:
  - Current address increments by 1 after each D_GAP and wraps modulo 2^DATA_W (0xFF -> 0x00).
  - Beat count = burst_len + 1; burst_len at its maximum gives 2^BURST_W beats.
- Completion: done pulses on the D_GAP -> IDLE edge, and busy falls on the same edge.
- start while busy: ignored, not queued.
- start on the cycle done is high: ignored.
- Earliest next accept is the cycle after done.
- Input changes after accept: addr and rnw changes mid-transfer have no effect.

Optional Feature:
- RTC_SEQ_ABORT_EN defined:
  - Adds input abort (1 bit).
  - If abort = 1 in any SETUP or PULSE state, go to the current phase's HOLD on the next edge, raising the strobe.
  - Then finish the GAP and go to IDLE with a done pulse; remaining beats are dropped.
  - An aborted read produces no rdata_valid.
  - Adds output aborted, a one-cycle pulse coincident with done.
  - abort in HOLD or GAP states: no effect other than cancelling further beats.
- Not defined: no abort port; every transfer runs to completion.

Decomposition:
- Shared package (rtc_pkg):
  - State encoding localparams (4-bit).
  - Default timing constants.
  - Helper clog2 function for the phase counter width.
- One natural sub-module, rtc_phase_timer: loadable down-counter with a terminal-count flag, instantiated once.

Test Plan:
- Single write, addr=0x21, wdata=0x15, defaults:
  - Address phase: cs_n low 8 cycles, bus_out=0x21, wr_n low 4 cycles.
  - Data phase: wr_n low 4 cycles with bus_out=0x15.
  - done pulses 24 cycles after accept.
- Single read, addr=0x42, bus_in=0x37:
  - rd_n low 4 cycles, bus_oe=0.
  - rdata=0x37 with one rdata_valid pulse; wr_n never low in the data phase.
- Burst write, addr=0xFE, burst_len=2, wdata 0xA0/0xA1/0xA2:
  - Address phases drive 0xFE, 0xFF, 0x00.
  - Exactly 3 wdata_ack pulses; done after 72 cycles.
- start pulsed at cycle 10 of an active transfer: ignored, exactly one done.
- reset asserted during D_PULSE of a write:
  - wr_n and cs_n go to 1 and bus_oe to 0 without waiting for a clock edge.
  - No done; the next start runs normally.
- With RTC_SEQ_ABORT_EN, abort during a D_PULSE read:
  - HOLD(2)+GAP(4) cycles follow, then done and aborted pulse together.
  - No rdata_valid.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus sequencer: state encoding, default phase
// timing and the phase-counter width helper.
package rtc_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_A_SETUP = 4'd1;
    localparam logic [3:0] ST_A_PULSE = 4'd2;
    localparam logic [3:0] ST_A_HOLD  = 4'd3;
    localparam logic [3:0] ST_A_GAP   = 4'd4;
    localparam logic [3:0] ST_D_SETUP = 4'd5;
    localparam logic [3:0] ST_D_PULSE = 4'd6;
    localparam logic [3:0] ST_D_HOLD  = 4'd7;
    localparam logic [3:0] ST_D_GAP   = 4'd8;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_HOLD_CYC  = 2;
    localparam int DEF_GAP_CYC   = 4;
    localparam int DEF_BURST_W   = 4;

    // Bits needed to hold max_len-1, never less than one.
    function automatic int clog2(input int max_len);
        int w;
        w = 1;
        while ((1 << w) < max_len) w++;
        return w;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times one bus phase; tc flags the last cycle.
module rtc_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus sequencer for the external RTC with burst support.
// Optional abort input/aborted output enabled by defining RTC_SEQ_ABORT_EN.
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int BURST_W   = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rnw,
    input  logic [DATA_W-1:0]  addr,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DATA_W-1:0]  wdata,
    output logic               wdata_ack,
    output logic [DATA_W-1:0]  rdata,
    output logic               rdata_valid,
    output logic               busy,
    output logic               done,
    output logic               ad_n,
    output logic               cs_n,
    output logic               rd_n,
    output logic               wr_n,
    output logic [DATA_W-1:0]  bus_out,
    output logic               bus_oe,
    input  logic [DATA_W-1:0]  bus_in
`ifdef RTC_SEQ_ABORT_EN
    ,
    input  logic               abort,
    output logic               aborted
`endif
);

    localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CD  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = clog2(MAX_LEN);

    logic [3:0]         state, nxt;
    logic               load, tc;
    logic [CNT_W-1:0]   load_val, count;
    logic               rnw_q, stop_q, abort_req, stop, last_beat, finish, capture;
    logic [BURST_W-1:0] burst_q, beat_q;
    logic [DATA_W-1:0]  cur_addr;

`ifdef RTC_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] phase_len(input logic [3:0] st);
        case (st)
            ST_A_SETUP, ST_D_SETUP: phase_len = CNT_W'(SETUP_CYC - 1);
            ST_A_PULSE, ST_D_PULSE: phase_len = CNT_W'(PULSE_CYC - 1);
            ST_A_HOLD,  ST_D_HOLD:  phase_len = CNT_W'(HOLD_CYC - 1);
            ST_A_GAP,   ST_D_GAP:   phase_len = CNT_W'(GAP_CYC - 1);
            default:                phase_len = '0;
        endcase
    endfunction

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
    );

    assign stop      = stop_q | abort_req;
    assign last_beat = (beat_q == burst_q);
    assign finish    = (state != ST_IDLE) && (nxt == ST_IDLE);
    assign capture   = (state == ST_D_PULSE) && tc && rnw_q && !abort_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // done blocks a same-cycle restart so the next accept is the cycle after it.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    if (start && !done) nxt = ST_A_SETUP;
            ST_A_SETUP: if (abort_req) nxt = ST_A_HOLD; else if (tc) nxt = ST_A_PULSE;
            ST_A_PULSE: if (abort_req || tc) nxt = ST_A_HOLD;
            ST_A_HOLD:  if (tc) nxt = ST_A_GAP;
            ST_A_GAP:   if (tc) nxt = stop ? ST_IDLE : ST_D_SETUP;
            ST_D_SETUP: if (abort_req) nxt = ST_D_HOLD; else if (tc) nxt = ST_D_PULSE;
            ST_D_PULSE: if (abort_req || tc) nxt = ST_D_HOLD;
            ST_D_HOLD:  if (tc) nxt = ST_D_GAP;
            ST_D_GAP:   if (tc) nxt = (stop || last_beat) ? ST_IDLE : ST_A_SETUP;
            default:    nxt = ST_IDLE;
        endcase
        load     = (nxt != state);
        load_val = phase_len(nxt);
    end

    always_comb begin
        cs_n      = 1'b1;
        ad_n      = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        bus_oe    = 1'b0;
        wdata_ack = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_A_SETUP, ST_A_HOLD: begin
                cs_n = 1'b0; ad_n = 1'b0; bus_oe = 1'b1;
            end
            ST_A_PULSE: begin
                cs_n = 1'b0; ad_n = 1'b0; bus_oe = 1'b1; wr_n = 1'b0;
            end
            ST_D_SETUP, ST_D_HOLD: begin
                cs_n = 1'b0; bus_oe = !rnw_q;
                wdata_ack = (state == ST_D_SETUP) && !rnw_q && (count == CNT_W'(SETUP_CYC - 1));
            end
            ST_D_PULSE: begin
                cs_n = 1'b0; bus_oe = !rnw_q; rd_n = !rnw_q; wr_n = rnw_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnw_q       <= 1'b0;
            burst_q     <= '0;
            beat_q      <= '0;
            cur_addr    <= '0;
            bus_out     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            rdata_valid <= capture;
            done        <= finish;
            if (capture)
                rdata <= bus_in;
            if (state == ST_IDLE)
                stop_q <= 1'b0;
            else if (abort_req)
                stop_q <= 1'b1;
            if (state == ST_IDLE && nxt == ST_A_SETUP) begin
                rnw_q    <= rnw;
                burst_q  <= burst_len;
                beat_q   <= '0;
                cur_addr <= addr;
                bus_out  <= addr;
            end else if (state == ST_D_GAP && tc) begin
                cur_addr <= cur_addr + 1'b1;
                if (nxt == ST_A_SETUP) begin
                    beat_q  <= beat_q + 1'b1;
                    bus_out <= cur_addr + 1'b1;
                end
            end else if (wdata_ack) begin
                bus_out <= wdata;
            end
        end
    end

`ifdef RTC_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            aborted <= 1'b0;
        else
            aborted <= finish && stop;
    end
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Randomized self-checking bench for rtc_bus_sequencer; expected pin activity is
// computed from each cycle's position within the beat timeline.
module tb_rtc_bus_sequencer;

    localparam int S     = 2;
    localparam int P     = 4;
    localparam int H     = 2;
    localparam int G     = 4;
    localparam int PH    = S + P + H + G;
    localparam int BEAT  = 2 * PH;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rnw = 1'b0;
    logic [7:0] addr = '0;
    logic [3:0] burst_len = '0;
    logic [7:0] wdata = '0;
    logic [7:0] bus_in = '0;
    logic       wdata_ack, rdata_valid, busy, done, ad_n, cs_n, rd_n, wr_n, bus_oe;
    logic [7:0] rdata, bus_out;
`ifdef RTC_SEQ_ABORT_EN
    logic       aborted;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int force_bin = -1;

    rtc_bus_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rnw         (rnw),
        .addr        (addr),
        .burst_len   (burst_len),
        .wdata       (wdata),
        .wdata_ack   (wdata_ack),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .done        (done),
        .ad_n        (ad_n),
        .cs_n        (cs_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .bus_in      (bus_in)
`ifdef RTC_SEQ_ABORT_EN
        ,
        .abort       (1'b0),
        .aborted     (aborted)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge; issues one transfer and checks every cycle of it.
    task automatic run_xfer(input bit rd, input logic [7:0] a, input logic [3:0] bl,
                            input int poke, input bit done_poke, input int wbase);
        logic [7:0] wq [16];
        logic [7:0] exp_rd, v, ea;
        logic [8:0] ep;
        int n, total, b, o, half, p, acks, valids, dones;
        bit act, stb;
        n = int'(bl) + 1;
        total = BEAT * n;
        acks = 0; valids = 0; dones = 0; exp_rd = '0;
        for (int i = 0; i < 16; i++)
            wq[i] = (wbase >= 0) ? 8'(wbase + i) : 8'($urandom);
        start = 1'b1; rnw = rd; addr = a; burst_len = bl;
        for (int k = 1; k <= total + 2; k++) begin
            @(negedge clk);
            b = (k - 1) / BEAT; o = (k - 1) % BEAT; half = o / PH; p = o % PH;
            act = (k <= total) && (p < S + P + H);
            stb = (k <= total) && (p >= S) && (p < S + P);
            if (k <= total)
                ep = {!act, !(half == 0 && act), !(stb && half == 1 && rd),
                      !(stb && (half == 0 || !rd)), act && (half == 0 || !rd),
                      1'b1, 1'b0, half == 1 && p == 0 && !rd, half == 1 && rd && p == S + P};
            else
                ep = {5'b11110, 1'b0, k == total + 1, 2'b00};
            chk("pins", {cs_n, ad_n, rd_n, wr_n, bus_oe, busy, done, wdata_ack, rdata_valid}, 32'(ep));
            chk("exclusive", 32'((!rd_n && !wr_n) || (bus_oe && !rd_n)), 0);
            if (act && half == 0) begin
                ea = a + 8'(b);
                chk("addr_bus", bus_out, ea);
            end else if (act && !rd && p >= 1) begin
                chk("wdata_bus", bus_out, wq[b]);
            end
            if (k <= total && half == 1 && rd && p == S + P)
                chk("rdata", rdata, exp_rd);
            acks += int'(wdata_ack); valids += int'(rdata_valid); dones += int'(done);
            start = (k == poke) || (done_poke && k == total + 1);
            rnw = 1'($urandom); addr = 8'($urandom);
            wdata = (k <= total) ? wq[b] : 8'($urandom);
            v = (force_bin >= 0) ? 8'(force_bin) : 8'($urandom);
            bus_in = v;
            if (k <= total && half == 1 && rd && p == S + P - 1)
                exp_rd = v;
        end
        chk("ack_count", acks, rd ? 0 : n);
        chk("valid_count", valids, rd ? n : 0);
        chk("done_count", dones, 1);
    endtask

    task automatic reset_mid();
        start = 1'b1; rnw = 1'b0; addr = 8'h55; burst_len = 4'd0; wdata = 8'h66;
        for (int k = 1; k <= BEAT / 2 + S + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_wr_n", wr_n, 0);
        #2 reset = 1'b0;
        #1 chk("async_reset", {cs_n, wr_n, rd_n, ad_n, bus_oe, busy}, 6'b111100);
        @(negedge clk);
        chk("reset_bus_out", bus_out, 0);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy, cs_n}, 3'b001);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl, pk;
        repeat (2) @(negedge clk);
        chk("reset_pins", {cs_n, ad_n, rd_n, wr_n, bus_oe, busy, done, wdata_ack, rdata_valid}, 9'b111100000);
        chk("reset_bus_out", bus_out, 0);
        chk("reset_rdata", rdata, 0);
        reset = 1'b1;
        @(negedge clk);
        run_xfer(1'b0, 8'h21, 4'd0, 0, 1'b1, 8'h15);
        force_bin = 8'h37;
        run_xfer(1'b1, 8'h42, 4'd0, 0, 1'b0, -1);
        chk("read_value", rdata, 8'h37);
        force_bin = -1;
        run_xfer(1'b0, 8'hFE, 4'd2, 0, 1'b1, 8'hA0);
        run_xfer(1'b0, 8'h10, 4'd0, 10, 1'b0, -1);
        run_xfer(1'b1, 8'hF8, 4'd15, 0, 1'b1, -1);
        reset_mid();
        run_xfer(1'b0, 8'h21, 4'd0, 0, 1'b0, 8'h15);
        for (int t = 0; t < 12; t++) begin
            bl = $urandom_range(0, 3);
            pk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, BEAT * (bl + 1) + 1) : 0;
            run_xfer(1'($urandom), 8'($urandom), 4'(bl), pk, 1'($urandom), -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
